// File: rtl/alu_uart_pkg.sv
// ============================================================================
// Module   : alu_uart_pkg
// Purpose  : Shared types and constants for the alu_uart_tx serial transmitter.
//            Holds the transmitter state encoding, the data width and the
//            default clocks-per-bit divisor (10 MHz / 115200).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    // ST_PARITY is always part of the encoding so the state width does not
    // change between the plain and the parity build.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_uart_tx_if.sv
// ============================================================================
// Module   : alu_uart_tx_if
// Purpose  : Valid/ready byte handshake between the ALU result path and the
//            UART transmitter.
// Signals  : tx_data  - byte to send
//            tx_valid - tx_data is valid (producer)
//            tx_ready - transmitter can accept (consumer)
// Modports : master (producer), slave (transmitter)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//            flags the terminal count as a one-cycle bit tick.
// Ports    : clk     - system clock
//            rst_n   - asynchronous active-low reset
//            clr_i   - synchronous clear (restart the bit period)
//            en_i    - count enable
//            tick_o  - high in the last cycle of each bit period
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  clr_i,
    input  wire  en_i,
    output logic tick_o
);

    localparam int             CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == C_TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_uart_tx.sv
// ============================================================================
// Module   : alu_uart_tx
// Purpose  : 8N1 UART transmitter for ALU results. Accepts one byte per
//            valid/ready handshake and shifts it out LSB first on tx.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            ena    - enable; gates new acceptances only
//            bus    - alu_uart_tx_if.slave (tx_data / tx_valid / tx_ready)
//            tx     - serial line, idle high (registered)
//            busy   - high whenever a frame is in progress
// Options  : ALU_UART_TX_PARITY_EN - insert an even-parity bit after D7
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_uart_tx
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  wire           clk,
    input  wire           rst_n,
    input  wire           ena,
    alu_uart_tx_if.slave  bus,
    output logic          tx,
    output logic          busy
);

    localparam logic [2:0] C_LAST_IDX = 3'(DATA_BITS - 1);

    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     idx_q,   idx_d;
    logic           tx_q,    tx_d;
    logic           w_tick;
    logic           w_accept;
`ifdef ALU_UART_TX_PARITY_EN
    logic           parity_q;
`endif

    // rst_n is folded in so the producer never sees ready during reset.
    assign bus.tx_ready = ena && rst_n && (state_q == ST_IDLE);
    assign w_accept     = bus.tx_valid && bus.tx_ready;
    assign busy         = (state_q != ST_IDLE);
    assign tx           = tx_q;

    // Cleared on accept so the start bit lasts a full period from that edge.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (w_accept),
        .en_i   (busy),
        .tick_o (w_tick)
    );

    // ---------------- state / datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

`ifdef ALU_UART_TX_PARITY_EN
    // Parity is taken from the byte as latched; the shift register is
    // consumed while the data bits go out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (w_accept) begin
            parity_q <= ^bus.tx_data;
        end
    end
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_accept) state_d = ST_START;
            ST_START:  if (w_tick)   state_d = ST_DATA;
            ST_DATA: begin
                if (w_tick && (idx_q == C_LAST_IDX)) begin
`ifdef ALU_UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef ALU_UART_TX_PARITY_EN
            ST_PARITY: if (w_tick)   state_d = ST_STOP;
`endif
            ST_STOP:   if (w_tick)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    // tx is registered, so tx_d is loaded with the level of the bit that
    // starts at the coming edge.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_accept) begin
                    shift_d = bus.tx_data;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) tx_d = shift_q[0];
            end
            ST_DATA: begin
                if (w_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == C_LAST_IDX) begin
`ifdef ALU_UART_TX_PARITY_EN
                        tx_d = parity_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef ALU_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) tx_d = 1'b1;
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_uart_tx.sv
// ============================================================================
// Module   : tb_alu_uart_tx
// Purpose  : Directed self-checking bench for alu_uart_tx with CLKS_PER_BIT=4.
//            Expected line levels come from a small frame model (exp_bit).
// Options  : ALU_UART_TX_PARITY_EN - bench expects the 11-bit parity frame
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_uart_tx;

    localparam int N = 4;
`ifdef ALU_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk;
    logic rst_n;
    logic ena;
    logic tx;
    logic busy;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   t0;
    int   t1;

    alu_uart_tx_if bus ();

    alu_uart_tx #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Line level of frame bit k for byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef ALU_UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers d and returns at the sample point right after the accepting edge.
    task automatic accept(input logic [7:0] d, input bit hold);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 200 && bus.tx_ready !== 1'b1; i++) tick();
        chk("accept_ready", {31'd0, bus.tx_ready}, 32'd1);
        tick();
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    // Checks frame cycles [from, to) counted from the sample after accept.
    task automatic check_bits(input logic [7:0] d, input int from, input int to);
        for (int c = from; c < to; c++) begin
            chk($sformatf("tx_d%02h_c%0d", d, c), {31'd0, tx}, {31'd0, exp_bit(d, c / N)});
            chk($sformatf("busy_d%02h_c%0d", d, c), {31'd0, busy}, 32'd1);
            tick();
        end
    endtask

    task automatic frame_end();
        chk("end_busy",  {31'd0, busy},         32'd0);
        chk("end_tx",    {31'd0, tx},           32'd1);
        chk("end_ready", {31'd0, bus.tx_ready}, {31'd0, ena});
    endtask

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // ---- reset ----
        tick();
        tick();
        chk("rst_tx",    {31'd0, tx},           32'd1);
        chk("rst_busy",  {31'd0, busy},         32'd0);
        chk("rst_ready", {31'd0, bus.tx_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk("idle_tx", {31'd0, tx}, 32'd1);
            tick();
        end

        // ---- single byte 0xA5 ----
        accept(8'hA5, 1'b0);
        check_bits(8'hA5, 0, FB * N);
        frame_end();

        // ---- back-to-back 0x00 then 0xFF ----
        accept(8'h00, 1'b1);
        t0 = cyc;
        bus.tx_data = 8'hFF;
        check_bits(8'h00, 0, FB * N);
        frame_end();
        tick();
        t1 = cyc;
        bus.tx_valid = 1'b0;
        chk("b2b_period", t1 - t0, FB * N + 1);
        check_bits(8'hFF, 0, FB * N);
        frame_end();

        // ---- data changes mid-frame ----
        accept(8'hA5, 1'b1);
        bus.tx_data = 8'h3C;
        check_bits(8'hA5, 0, FB * N);
        frame_end();
        tick();
        bus.tx_valid = 1'b0;
        check_bits(8'h3C, 0, FB * N);
        frame_end();

        // ---- reset during D3 ----
        accept(8'h5A, 1'b0);
        check_bits(8'h5A, 0, 4 * N + 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx",    {31'd0, tx},           32'd1);
        chk("midrst_busy",  {31'd0, busy},         32'd0);
        chk("midrst_ready", {31'd0, bus.tx_ready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("midrst_idle_tx", {31'd0, tx}, 32'd1);
            chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        accept(8'h81, 1'b0);
        check_bits(8'h81, 0, FB * N);
        frame_end();

        // ---- ena dropped mid-frame ----
        accept(8'h96, 1'b0);
        check_bits(8'h96, 0, 10);
        ena          = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h11;
        check_bits(8'h96, 10, FB * N);
        frame_end();
        for (int i = 0; i < 10; i++) begin
            chk("ena_off_ready", {31'd0, bus.tx_ready}, 32'd0);
            chk("ena_off_tx",    {31'd0, tx},           32'd1);
            tick();
        end
        bus.tx_valid = 1'b0;
        ena          = 1'b1;
        #1;
        chk("ena_on_ready", {31'd0, bus.tx_ready}, 32'd1);

`ifdef ALU_UART_TX_PARITY_EN
        // ---- parity values ----
        accept(8'h07, 1'b0);
        check_bits(8'h07, 0, 9 * N);
        chk("parity_07", {31'd0, tx}, 32'd1);
        check_bits(8'h07, 9 * N, FB * N);
        frame_end();
        accept(8'h03, 1'b0);
        check_bits(8'h03, 0, 9 * N);
        chk("parity_03", {31'd0, tx}, 32'd0);
        check_bits(8'h03, 9 * N, FB * N);
        frame_end();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_uart_tx.md
# alu_uart_tx

Serial transmitter that sits directly downstream of the `tt_um_alu` result path. It accepts one 8-bit result per valid/ready handshake and serialises it as a standard 8N1 UART frame, LSB first, on a single output pin. The frame rate is set by a fixed clocks-per-bit divisor. The top level drives the pin through a dedicated `uo_out` bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per serial bit (10 MHz / 115200). Legal range ≥ 2.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  design-selected enable; gates new acceptances only
- `tx_data`  in  8  byte to send (ALU result)
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  block can accept; equals `ena && state==IDLE`
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high whenever state != IDLE

## Operation
- States: IDLE → START → DATA → STOP → IDLE. With parity enabled, PARITY sits between DATA and STOP.
- Accept happens at a clock edge where `tx_valid && tx_ready`. At that edge:
  - `tx_data` is latched into the shift register.
  - The bit index is cleared.
  - The baud counter is cleared.
  - State becomes START.
- Baud counter runs 0..`CLKS_PER_BIT`-1. The terminal count is the bit tick. Width is `$clog2(CLKS_PER_BIT)`.
- START: `tx`=0 for one bit. On tick, go to DATA.
- DATA: `tx` = shift register bit 0. On tick, shift right and increment the index. After index 7, go to STOP (or PARITY).
- STOP: `tx`=1 for one bit. On tick, go to IDLE.
- `tx_data` and `tx_valid` are ignored while not IDLE. The latched byte is immutable for the whole frame.
- `ena` deasserted mid-frame does not abort. The frame completes, and no new accept occurs until `ena` is high again.
- Reset (asynchronous assert) takes effect immediately:
  - Outputs: `tx`=1, `busy`=0, `tx_ready`=0 while `rst_n`=0.
  - State: IDLE.
  - Shift register, index and counter: all 0.
  - A frame in flight is discarded; no partial-frame resume.

## Timing
- `tx` is registered. It falls at the accepting edge, so zero cycles elapse between handshake and start bit.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- With accept at edge E0, STOP ends at edge E0+10·N, when state returns to IDLE. `tx_ready` is high in the following cycle.
- The earliest next accept is edge E0+10·N+1. The back-to-back frame period is therefore 10·N+1 cycles, so the line stays high for at least N+1 cycles between frames.
- `busy` rises at the accepting edge and falls at E0+10·N.
- `tx_ready` has combinational dependency on `ena` only; no combinational path from `tx_valid`.

## Configuration
- `ALU_UART_TX_PARITY_EN` defined: PARITY state is inserted after D7.
  - Drives `tx` = even parity (XOR of the 8 latched bits) for one bit.
  - Frame is 11 bits; the back-to-back period is 11·N+1.
- Undefined: no PARITY state, no parity logic; frame is 8N1 as above.

## Structure
- Package `alu_uart_pkg`:
  - state enum `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP` (`ST_PARITY` is present even when unused)
  - `DATA_BITS`=8
  - `DEFAULT_CLKS_PER_BIT`=87
- Sub-module `uart_baud_tick`: parameterised counter with synchronous clear, producing the one-cycle bit tick. FSM, shift register and parity stay in `alu_uart_tx`.

## Test plan
Bench uses `CLKS_PER_BIT`=4, `ena`=1 unless stated.
- Reset: `rst_n`=0 → `tx`=1, `busy`=0, `tx_ready`=0. After release → `tx_ready`=1, `tx`=1 steady for 20 cycles.
- Single byte 0xA5 → `tx` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1. `busy` is high for 40 cycles, then `tx_ready` rises.
- Back-to-back 0x00 then 0xFF, `tx_valid` held high → the second start bit falls exactly 41 cycles after the first. Bits are 0×8 then 1×8.
- `tx_data` changed to 0x3C mid-frame of 0xA5 with `tx_valid`=1 → the serialised bits remain those of 0xA5, and 0x3C is sent only after `tx_ready` returns.
- `rst_n` pulsed low during D3 → `tx`=1 immediately, and no residual bits follow. After release, a new 0x81 is sent correctly. Deassert `ena` mid-frame → the frame completes and `tx_ready` stays 0.
- `ALU_UART_TX_PARITY_EN` build: 0x07 → parity bit 1; 0x03 → parity bit 0. Back-to-back period is 45 cycles.
